crono_countdown: RTL

Countdown engine for the chronometer (timer) function: consumes the hours/minutes/seconds value produced by the chronometer programming state machine and counts it down to zero in BCD at one decrement per second. It also drives the active flag, the end-of-count pulse and the ring (alarm) output. It sits between the chronometer programming FSM and the display/alarm logic, on the same system clock as the RTC interface.

---
 rtl/crono_countdown.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/crono_countdown.sv
`default_nettype none
//==============================================================================
// Module      : crono_countdown
// Description : BCD hh:mm:ss countdown engine for the chronometer. Drives the
//               active flag, the end-of-count pulse and the ring output.
//               Pause/resume on inicio is built when CRONO_PAUSA_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module crono_countdown #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned RING_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       programar,
    input  logic       inicio,
    input  logic       apagar,
    input  logic [7:0] horas_in,
    input  logic [7:0] minutos_in,
    input  logic [7:0] segundos_in,
    output logic [7:0] horas_cnt,
    output logic [7:0] minutos_cnt,
    output logic [7:0] segundos_cnt,
    output logic       activo,
    output logic       fin,
    output logic       ring
);

    localparam int unsigned c_PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned c_RSEC_W  = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [c_RSEC_W-1:0]  c_RSEC_LAST  = c_RSEC_W'(RING_SECONDS - 1);
    localparam logic [c_RSEC_W-1:0]  c_RSEC_ONE   = c_RSEC_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_RING  = 2'd2;
`ifdef CRONO_PAUSA_EN
    localparam logic [1:0] c_PAUSE = 2'd3;
`endif

    logic [1:0]           r_state, w_stateNext;
    logic [7:0]           r_horas, r_minutos, r_segundos;
    logic [7:0]           w_horasNext, w_minutosNext, w_segundosNext;
    logic [c_PRESC_W-1:0] r_presc, w_prescNext;
    logic [c_RSEC_W-1:0]  r_ringSec, w_ringSecNext;
    logic                 r_inicioPrev;
    logic                 r_activo, r_fin, r_ring;
    logic                 w_finNext, w_activoNext;
    logic                 w_inicioEdge, w_countZero, w_decZero;
    logic                 w_segBorrow, w_minBorrow;
    logic [7:0]           w_horDec, w_minDec, w_segDec;

    // Invalid digits or out-of-range values saturate to the field limit.
    function automatic logic [7:0] clampBcd(input logic [7:0] value, input logic [7:0] limit);
        if (value[7:4] > 4'd9 || value[3:0] > 4'd9 || value > limit) begin
            return limit;
        end else begin
            return value;
        end
    endfunction

    function automatic logic [7:0] decBcd(input logic [7:0] value, input logic [7:0] wrapVal);
        if (value[3:0] != 4'd0) begin
            return {value[7:4], value[3:0] - 4'd1};
        end else if (value[7:4] != 4'd0) begin
            return {value[7:4] - 4'd1, 4'd9};
        end else begin
            return wrapVal;
        end
    endfunction

    assign w_inicioEdge = inicio & ~r_inicioPrev;
    assign w_countZero  = ({r_horas, r_minutos, r_segundos} == 24'h0);

    assign w_segDec    = decBcd(r_segundos, 8'h59);
    assign w_segBorrow = (r_segundos == 8'h00);
    assign w_minDec    = w_segBorrow ? decBcd(r_minutos, 8'h59) : r_minutos;
    assign w_minBorrow = w_segBorrow && (r_minutos == 8'h00);
    // Hours are never zero when a borrow reaches them, so no wrap value is needed.
    assign w_horDec    = w_minBorrow ? decBcd(r_horas, 8'h00) : r_horas;
    assign w_decZero   = ({w_horDec, w_minDec, w_segDec} == 24'h0);

    always_comb begin
        w_stateNext    = r_state;
        w_horasNext    = r_horas;
        w_minutosNext  = r_minutos;
        w_segundosNext = r_segundos;
        w_prescNext    = r_presc;
        w_ringSecNext  = r_ringSec;
        w_finNext      = 1'b0;

        if (programar) begin
            w_stateNext    = c_IDLE;
            w_horasNext    = clampBcd(horas_in, 8'h23);
            w_minutosNext  = clampBcd(minutos_in, 8'h59);
            w_segundosNext = clampBcd(segundos_in, 8'h59);
            w_prescNext    = '0;
            w_ringSecNext  = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_inicioEdge && !w_countZero) begin
                        w_stateNext = c_RUN;
                        w_prescNext = '0;
                    end
                end
                c_RUN: begin
`ifdef CRONO_PAUSA_EN
                    if (w_inicioEdge) begin
                        w_stateNext = c_PAUSE;
                    end else
`endif
                    if (r_presc == c_PRESC_LAST) begin
                        w_prescNext    = '0;
                        w_horasNext    = w_horDec;
                        w_minutosNext  = w_minDec;
                        w_segundosNext = w_segDec;
                        if (w_decZero) begin
                            w_stateNext   = c_RING;
                            w_finNext     = 1'b1;
                            w_ringSecNext = '0;
                        end
                    end else begin
                        w_prescNext = r_presc + c_PRESC_ONE;
                    end
                end
                c_RING: begin
                    if (apagar) begin
                        w_stateNext   = c_IDLE;
                        w_prescNext   = '0;
                        w_ringSecNext = '0;
                    end else if (r_presc == c_PRESC_LAST) begin
                        // The prescaler doubles as the sub-second timer of the ring period.
                        w_prescNext = '0;
                        if (r_ringSec == c_RSEC_LAST) begin
                            w_stateNext   = c_IDLE;
                            w_ringSecNext = '0;
                        end else begin
                            w_ringSecNext = r_ringSec + c_RSEC_ONE;
                        end
                    end else begin
                        w_prescNext = r_presc + c_PRESC_ONE;
                    end
                end
`ifdef CRONO_PAUSA_EN
                c_PAUSE: begin
                    if (w_inicioEdge) begin
                        w_stateNext = c_RUN;
                    end
                end
`endif
                default: begin
                    w_stateNext = c_IDLE;
                end
            endcase
        end
    end

`ifdef CRONO_PAUSA_EN
    assign w_activoNext = (w_stateNext == c_RUN) || (w_stateNext == c_PAUSE);
`else
    assign w_activoNext = (w_stateNext == c_RUN);
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= c_IDLE;
            r_horas      <= 8'h00;
            r_minutos    <= 8'h00;
            r_segundos   <= 8'h00;
            r_presc      <= '0;
            r_ringSec    <= '0;
            r_inicioPrev <= 1'b0;
            r_activo     <= 1'b0;
            r_fin        <= 1'b0;
            r_ring       <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_horas      <= w_horasNext;
            r_minutos    <= w_minutosNext;
            r_segundos   <= w_segundosNext;
            r_presc      <= w_prescNext;
            r_ringSec    <= w_ringSecNext;
            r_inicioPrev <= inicio;
            r_activo     <= w_activoNext;
            r_fin        <= w_finNext;
            r_ring       <= (w_stateNext == c_RING);
        end
    end

    assign horas_cnt    = r_horas;
    assign minutos_cnt  = r_minutos;
    assign segundos_cnt = r_segundos;
    assign activo       = r_activo;
    assign fin          = r_fin;
    assign ring         = r_ring;

endmodule
`default_nettype wire
